// File: rtl/beam_stream_ctrl.sv
// beam_stream_ctrl: byte-stream front-end and drain/accumulate back-end for
// the day-7 splitter core. Converts an ASCII valid/ready stream into en /
// split_in column strobes, then drains LINE_LENGTH columns and sums count_out.
// Optional build macro: BEAM_LINE_CHECK_EN adds the sticky err_line output
// and the column-length check behind it.
module beam_stream_ctrl #(
  parameter int LINE_LENGTH     = 141,
  parameter int LONG_DATA_WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic                       en,
  output logic                       split_in,
  input  logic [LONG_DATA_WIDTH-1:0] count_out,
  output logic [LONG_DATA_WIDTH-1:0] sum_out,
  output logic                       sum_valid
`ifdef BEAM_LINE_CHECK_EN
  ,
  output logic                       err_line
`endif
);

  localparam int CW = $clog2(LINE_LENGTH + 1);

  localparam logic [1:0] ST_STREAM = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  logic [1:0]    state;
  logic [CW-1:0] drain_cnt;
  logic          accept;
  logic          is_caret;
  logic          is_lf;
  logic          is_cr;
  logic          advance;

  // Unsigned accumulate that wraps silently modulo 2^LONG_DATA_WIDTH.
  function automatic logic [LONG_DATA_WIDTH-1:0] acc_wrap(
    input logic [LONG_DATA_WIDTH-1:0] a,
    input logic [LONG_DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  assign in_ready = (state == ST_STREAM);
  assign accept   = in_valid && in_ready;
  assign is_caret = (in_data == CH_CARET);
  assign is_lf    = (in_data == CH_LF);
  assign is_cr    = (in_data == CH_CR);
  assign advance  = !is_lf && !is_cr;

  // Main FSM: stream strobes, flush gap, drain/accumulate, hold result.
  // In DRAIN the first cycle shows en=0 (the flush gap as seen on en); the
  // following LINE_LENGTH cycles have en=1 and each of their edges adds
  // count_out, so accumulation is qualified by en.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_STREAM;
      en        <= 1'b0;
      split_in  <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_STREAM: begin
          if (accept) begin
            en       <= advance;
            split_in <= is_caret;
            if (in_last) state <= ST_FLUSH;
          end else begin
            en       <= 1'b0;
            split_in <= 1'b0;
          end
        end
        ST_FLUSH: begin
          en       <= 1'b0;
          split_in <= 1'b0;
          state    <= ST_DRAIN;
        end
        ST_DRAIN: begin
          split_in <= 1'b0;
          if (!en) begin
            en <= 1'b1;
          end else begin
            sum_out <= acc_wrap(sum_out, count_out);
            if (drain_cnt == CW'(LINE_LENGTH - 1)) begin
              en        <= 1'b0;
              sum_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
              en        <= 1'b1;
            end
          end
        end
        default: begin
          en        <= 1'b0;
          split_in  <= 1'b0;
          sum_valid <= 1'b1;
        end
      endcase
    end
  end

`ifdef BEAM_LINE_CHECK_EN
  logic [CW-1:0] col;

  // Column tracking and sticky line-length error; never affects flow.
  always_ff @(posedge clock) begin
    if (reset) begin
      col      <= '0;
      err_line <= 1'b0;
    end else if (accept) begin
      if (is_lf) begin
        if (col != CW'(LINE_LENGTH)) err_line <= 1'b1;
        col <= '0;
      end else if (advance) begin
        if (col == CW'(LINE_LENGTH)) err_line <= 1'b1;
        else                         col      <= col + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_beam_stream_ctrl.sv
// Directed bench for beam_stream_ctrl with LINE_LENGTH=5, 16-bit sums.
module tb_beam_stream_ctrl;

  localparam int LL = 5;
  localparam int LW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          en;
  logic          split_in;
  logic [LW-1:0] count_out;
  logic [LW-1:0] sum_out;
  logic          sum_valid;
`ifdef BEAM_LINE_CHECK_EN
  logic          err_line;
`endif

  int vectors = 0;
  int miscompares = 0;

  beam_stream_ctrl #(.LINE_LENGTH(LL), .LONG_DATA_WIDTH(LW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .en        (en),
    .split_in  (split_in),
    .count_out (count_out),
    .sum_out   (sum_out),
    .sum_valid (sum_valid)
`ifdef BEAM_LINE_CHECK_EN
    ,
    .err_line  (err_line)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last,
                      input logic exp_en, input logic exp_sp, input string tag);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, ".en"}, 64'(en), 64'(exp_en));
    chk({tag, ".split"}, 64'(split_in), 64'(exp_sp));
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    step();
    chk({tag, ".en"}, 64'(en), 64'd0);
    chk({tag, ".split"}, 64'(split_in), 64'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    count_out = '0;
    step();
    reset = 1'b0;
  endtask

  // Sends the 5-column line ".^..^" then '\n' flagged as the last byte.
  task automatic send_final_line(input string tag);
    send(8'h2E, 1'b0, 1'b1, 1'b0, {tag, ".c0"});
    send(8'h5E, 1'b0, 1'b1, 1'b1, {tag, ".c1"});
    send(8'h2E, 1'b0, 1'b1, 1'b0, {tag, ".c2"});
    send(8'h2E, 1'b0, 1'b1, 1'b0, {tag, ".c3"});
    send(8'h5E, 1'b0, 1'b1, 1'b1, {tag, ".c4"});
    send(8'h0A, 1'b1, 1'b0, 1'b0, {tag, ".lf"});
  endtask

  // Starts one cycle after the last byte was accepted. mode 0: count_out=1..5,
  // mode 1: count_out all ones.
  task automatic do_drain(input int mode, input string tag);
    chk({tag, ".rdy_n1"}, 64'(in_ready), 64'd0);
    step();
    chk({tag, ".flush_en"}, 64'(en), 64'd0);
    chk({tag, ".rdy_n2"}, 64'(in_ready), 64'd0);
    chk({tag, ".flush_sv"}, 64'(sum_valid), 64'd0);
    step();
    for (int i = 1; i <= LL; i++) begin
      chk($sformatf("%s.drain%0d_en", tag, i), 64'(en), 64'd1);
      chk($sformatf("%s.drain%0d_sp", tag, i), 64'(split_in), 64'd0);
      chk($sformatf("%s.drain%0d_sv", tag, i), 64'(sum_valid), 64'd0);
      count_out = (mode == 1) ? '1 : LW'(i);
      step();
    end
    count_out = '0;
    chk({tag, ".done_en"}, 64'(en), 64'd0);
    chk({tag, ".done_sv"}, 64'(sum_valid), 64'd1);
    chk({tag, ".done_rdy"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; count_out = '0;

    // Reset values
    do_reset();
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.en", 64'(en), 64'd0);
    chk("rst.split", 64'(split_in), 64'd0);
    chk("rst.sum", 64'(sum_out), 64'd0);
    chk("rst.sum_valid", 64'(sum_valid), 64'd0);
`ifdef BEAM_LINE_CHECK_EN
    chk("rst.err", 64'(err_line), 64'd0);
`endif

    // Back-to-back line ".^..^\n"
    send(8'h2E, 1'b0, 1'b1, 1'b0, "b2b0");
    send(8'h5E, 1'b0, 1'b1, 1'b1, "b2b1");
    send(8'h2E, 1'b0, 1'b1, 1'b0, "b2b2");
    send(8'h2E, 1'b0, 1'b1, 1'b0, "b2b3");
    send(8'h5E, 1'b0, 1'b1, 1'b1, "b2b4");
    send(8'h0A, 1'b0, 1'b0, 1'b0, "b2b5");
    chk("b2b.in_ready", 64'(in_ready), 64'd1);

    // Gaps and '\r'
    send(8'h2E, 1'b0, 1'b1, 1'b0, "gap0");
    send(8'h5E, 1'b0, 1'b1, 1'b1, "gap1");
    idle("gap_idle0");
    idle("gap_idle1");
    send(8'h2E, 1'b0, 1'b1, 1'b0, "gap2");
    send(8'h2E, 1'b0, 1'b1, 1'b0, "gap3");
    send(8'h5E, 1'b0, 1'b1, 1'b1, "gap4");
    send(8'h0D, 1'b0, 1'b0, 1'b0, "gap_cr");
    send(8'h0A, 1'b0, 1'b0, 1'b0, "gap_lf");
`ifdef BEAM_LINE_CHECK_EN
    chk("gap.err", 64'(err_line), 64'd0);
`endif

    // Final line, drain with 1..5, result held
    send_final_line("fin");
    do_drain(0, "dr");
    chk("dr.sum", 64'(sum_out), 64'd15);
    in_valid = 1'b1;
    in_data  = 8'h5E;
    step();
    step();
    in_valid = 1'b0;
    chk("hold.sum", 64'(sum_out), 64'd15);
    chk("hold.sv", 64'(sum_valid), 64'd1);
    chk("hold.en", 64'(en), 64'd0);
    chk("hold.rdy", 64'(in_ready), 64'd0);

    // Wrap: five all-ones counts
    do_reset();
    send_final_line("wr");
    do_drain(1, "wrd");
    chk("wrap.sum", 64'(sum_out), 64'h0000_0000_0000_FFFB);

    // Reset in the third drain cycle
    do_reset();
    send_final_line("mr");
    step();
    step();
    count_out = 16'd1;
    step();
    count_out = 16'd2;
    step();
    chk("mr.en3", 64'(en), 64'd1);
    reset = 1'b1;
    count_out = 16'd3;
    step();
    reset = 1'b0;
    count_out = '0;
    chk("mr.en", 64'(en), 64'd0);
    chk("mr.sum", 64'(sum_out), 64'd0);
    chk("mr.sv", 64'(sum_valid), 64'd0);
    chk("mr.rdy", 64'(in_ready), 64'd1);
    send_final_line("mr2");
    do_drain(0, "mr2d");
    chk("mr2.sum", 64'(sum_out), 64'd15);

`ifdef BEAM_LINE_CHECK_EN
    // Short line
    do_reset();
    send(8'h2E, 1'b0, 1'b1, 1'b0, "sh0");
    send(8'h5E, 1'b0, 1'b1, 1'b1, "sh1");
    send(8'h2E, 1'b0, 1'b1, 1'b0, "sh2");
    chk("sh.err_pre", 64'(err_line), 64'd0);
    send(8'h0A, 1'b0, 1'b0, 1'b0, "sh3");
    chk("sh.err", 64'(err_line), 64'd1);
    idle("sh_idle");
    chk("sh.err_sticky", 64'(err_line), 64'd1);

    // Long line: sixth column byte sets the error and is still forwarded
    do_reset();
    for (int i = 0; i < LL; i++) send(8'h2E, 1'b0, 1'b1, 1'b0, "lg");
    chk("lg.err_pre", 64'(err_line), 64'd0);
    send(8'h5E, 1'b0, 1'b1, 1'b1, "lg6");
    chk("lg.err", 64'(err_line), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/beam_stream_ctrl.md
# beam_stream_ctrl

Stream front-end and result back-end for the day-7 `splitter` core. The block accepts the puzzle input as an ASCII byte stream over a valid/ready handshake and converts it into the `en`/`split_in` column strobes that `splitter` consumes. After end-of-input it runs the drain phase: it holds `en` for `LINE_LENGTH` cycles, accumulates `splitter.count_out` into a final answer, and presents that answer with a valid flag. The bench no longer has to sequence `splitter` by hand.

## Interface
- `LINE_LENGTH`, default 141: columns per grid line. Must match the paired `splitter`.
- `clock` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high. Shared with `splitter`.
- `in_valid` input 1: `in_data` and `in_last` are valid this cycle.
- `in_ready` output 1: block accepts a byte this cycle.
- `in_data` input 8: ASCII character.
- `in_last` input 1: accompanies the final byte of the file.
- `en` output 1: column strobe to `splitter`. Registered.
- `split_in` output 1: 1 when the column holds `^`. Registered.
- `count_out` input `LONG_DATA_WIDTH`: per-column count from `splitter`. Valid combinationally while `en`=1 in DRAIN.
- `sum_out` output `LONG_DATA_WIDTH`: accumulated answer.
- `sum_valid` output 1: `sum_out` is final. Stays high until reset.
- `err_line` output 1: sticky line-length error. Present only with `BEAM_LINE_CHECK_EN`.

## Operation
- FSM states: STREAM, FLUSH, DRAIN, DONE. Reset state is STREAM.
- Handshake: `in_ready` = (state==STREAM), combinational from state. A byte is accepted on an edge where `in_valid && in_ready`.
- Per accepted byte, outputs take effect on the next cycle:
  - `'^'` (0x5E): `en`=1, `split_in`=1, column+1.
  - `'\n'` (0x0A): `en`=0 bubble, column cleared to 0.
  - `'\r'` (0x0D): `en`=0, column unchanged.
  - Any other byte, including `'.'` and `'S'`: `en`=1, `split_in`=0, column+1.
- Cycles in STREAM with no accepted byte drive `en`=0 and `split_in`=0.
- Accepted byte with `in_last`=1: the byte is processed as above, then STREAM→FLUSH.
- FLUSH: one cycle with `en`=0, then →DRAIN. This gap is mandatory even if the last byte was `\n`.
- DRAIN:
  - `en`=1 and `split_in`=0 every cycle.
  - Drain counter runs 0..`LINE_LENGTH`-1.
  - On every edge in DRAIN, `sum_out` ← `sum_out` + `count_out`.
  - After the `LINE_LENGTH`-th edge: →DONE.
- DONE: `en`=0, `sum_valid`=1, `sum_out` held. Further input is refused (`in_ready`=0).
- Arithmetic: the sum is `LONG_DATA_WIDTH` wide and unsigned, and wraps modulo 2^`LONG_DATA_WIDTH` with no overflow flag.
- The column counter is $clog2(`LINE_LENGTH`+1) bits and saturates at `LINE_LENGTH`.

## Timing
- Reset values: `in_ready`=1 (state is STREAM), `en`=0, `split_in`=0, `sum_out`=0, `sum_valid`=0, `err_line`=0. Column and drain counters are 0.
- Latency is 1 cycle from byte acceptance to the corresponding `en`/`split_in`.
- Throughput is 1 byte per cycle in STREAM.
- Sequence for the last accepted byte at edge N:
  - Cycle N+1: the last byte's strobe.
  - Cycle N+2: FLUSH (`en`=0).
  - Cycles N+3 .. N+2+`LINE_LENGTH`: DRAIN.
  - From cycle N+3+`LINE_LENGTH`: `sum_valid`=1.
- Reset asserted in any state takes priority: the next cycle shows reset values, and all in-flight input and partial sum are discarded.

## Configuration
- `BEAM_LINE_CHECK_EN` defined:
  - The `err_line` port exists.
  - `err_line` sets on accepting `\n` while column≠`LINE_LENGTH`.
  - `err_line` also sets on accepting a column-advancing byte while column==`LINE_LENGTH`. That byte is still forwarded.
  - `err_line` is visible the cycle after acceptance, is sticky until reset, and has no other effect on flow.
- `BEAM_LINE_CHECK_EN` undefined: no `err_line` port and no check logic. The column counter may also be removed.

## Test plan
All scenarios use `LINE_LENGTH`=5.
- Stream `".^..^\n"` back-to-back -> over 6 cycles `en`=1,1,1,1,1,0 and `split_in`=0,1,0,0,1,0, one cycle after each acceptance.
- Same line with `in_valid` low for 2 cycles after `'^'`, plus a `'\r'` before `'\n'` -> `en`=0 in the gap and `\r` cycles, and the strobe order is unchanged.
- Final `'\n'` sent with `in_last`=1, `count_out` forced to 1,2,3,4,5 during DRAIN -> one FLUSH cycle with `en`=0, then exactly 5 cycles with `en`=1, then `sum_out`=15 with `sum_valid`=1, held. `in_ready`=0 from FLUSH onward.
- `count_out`=all-ones for all 5 drain cycles -> `sum_out` = 2^`LONG_DATA_WIDTH`−5 (wrapped).
- With `BEAM_LINE_CHECK_EN`: `".^.\n"` -> `err_line`=1 the cycle after `\n` is accepted and stays set. With a 6-char line, `err_line` sets after the 6th char.
- Reset asserted in the 3rd DRAIN cycle -> the next cycle shows `en`=0, `sum_out`=0, `sum_valid`=0, `in_ready`=1, and a fresh stream then produces a correct sum.
